// File: rtl/prbs_ctrl_pkg.sv
// Shared types and helpers for the PRBS BER test sequencer.
package prbs_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_LOCK,
        ST_RUN,
        ST_DONE
    } state_e;

    localparam int POP_MAX_W = 64;   // widest error word popcount supports
    localparam int POP_W     = 7;    // enough to hold popcount of POP_MAX_W bits
    localparam int SAT_MAX_W = 64;   // widest counter the saturation helper supports

    // Counts ones in the low nbits of a zero-padded word.
    function automatic logic [POP_W-1:0] popcount(input logic [POP_MAX_W-1:0] v,
                                                  input int unsigned nbits);
        logic [POP_W-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < POP_MAX_W; i++)
            if (i < nbits)
                c = c + POP_W'(v[i]);
        return c;
    endfunction

    // True when a + b would exceed max (a must not already exceed max).
    function automatic logic sat_add_ovf(input logic [SAT_MAX_W-1:0] a,
                                         input logic [SAT_MAX_W-1:0] b,
                                         input logic [SAT_MAX_W-1:0] max);
        return b > (max - a);
    endfunction

endpackage

// File: rtl/prbs_sat_counter.sv
// Accumulator that saturates at all-ones; clear has priority over increment.
module prbs_sat_counter
    import prbs_ctrl_pkg::*;
#(
    parameter int W     = 32,
    parameter int INC_W = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clr,
    input  logic             inc_en,
    input  logic [INC_W-1:0] inc,
    output logic [W-1:0]     cnt
);

    logic [SAT_MAX_W-1:0] a_x, b_x, max_x;

    always_comb begin
        a_x             = '0;
        a_x[W-1:0]      = cnt;
        b_x             = '0;
        b_x[INC_W-1:0]  = inc;
        max_x           = '0;
        max_x[W-1:0]    = '1;
    end

    always_ff @(posedge CLK) begin
        if (RST || clr)
            cnt <= '0;
        else if (inc_en)
            cnt <= sat_add_ovf(a_x, b_x, max_x) ? '1 : cnt + W'(inc);
    end

endmodule

// File: rtl/prbs_test_ctrl.sv
// PRBS generator/checker sequencer: flush, lock acquisition, BER accumulation.
// Define PRBS_CTRL_WORD_LIMIT_EN to end RUN automatically after TEST_WORDS words.
module prbs_test_ctrl
    import prbs_ctrl_pkg::*;
#(
    parameter int NBITS      = 16,
    parameter int LOCK_WORDS = 64,
    parameter int LOSS_WORDS = 4,
    parameter int FLUSH_CYC  = 8,
    parameter int ERR_CNT_W  = 32,
    parameter int WORD_CNT_W = 48,
    parameter int INJ_BIT    = 0,
    parameter int TEST_WORDS = 2**20
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic                  STOP,
    input  logic                  INJECT,
    input  logic                  CHK_VALID,
    input  logic [NBITS-1:0]      CHK_ERR,
    output logic                  GEN_RST,
    output logic                  GEN_EN,
    output logic [NBITS-1:0]      GEN_ERR,
    output logic                  CHK_RST,
    output logic                  CHK_EN,
    output logic                  BUSY,
    output logic                  LOCKED,
    output logic                  LOCK_LOST,
    output logic                  DONE,
    output logic [ERR_CNT_W-1:0]  ERR_CNT,
    output logic [WORD_CNT_W-1:0] WORD_CNT
);

    localparam int FL_W = $clog2(FLUSH_CYC + 1);
    localparam int CL_W = $clog2(LOCK_WORDS + 1);
    localparam int BD_W = $clog2(LOSS_WORDS + 1);
    localparam logic [NBITS-1:0] INJ_MASK = NBITS'(1) << INJ_BIT;

    if (TEST_WORDS < 1 || NBITS > POP_MAX_W || ERR_CNT_W < POP_W) begin : g_param_chk
        $error("prbs_test_ctrl: unsupported parameter set");
    end

    state_e state, nxt;
    logic [FL_W-1:0] flush_cnt, flush_nxt;
    logic [CL_W-1:0] clean_cnt, clean_nxt;
    logic [BD_W-1:0] bad_cnt, bad_nxt;
    logic            lost_nxt, inj_nxt, clr_cnt, cnt_en;
    logic            chk_ok, chk_bad;
    logic [POP_MAX_W-1:0] err_pad;
    logic [POP_W-1:0]     err_pop;

    always_comb begin
        err_pad            = '0;
        err_pad[NBITS-1:0] = CHK_ERR;
        err_pop            = popcount(err_pad, NBITS);
        chk_ok             = CHK_VALID && (CHK_ERR == '0);
        chk_bad            = CHK_VALID && (CHK_ERR != '0);
    end

    always_comb begin
        nxt       = state;
        flush_nxt = flush_cnt;
        clean_nxt = clean_cnt;
        bad_nxt   = bad_cnt;
        lost_nxt  = LOCK_LOST;
        inj_nxt   = 1'b0;
        clr_cnt   = 1'b0;
        cnt_en    = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    nxt       = ST_FLUSH;
                    flush_nxt = FL_W'(FLUSH_CYC - 1);
                    clean_nxt = '0;
                    bad_nxt   = '0;
                    lost_nxt  = 1'b0;
                    clr_cnt   = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (STOP)
                    nxt = ST_DONE;
                else if (flush_cnt == '0) begin
                    nxt       = ST_LOCK;
                    clean_nxt = '0;
                end else
                    flush_nxt = flush_cnt - 1'b1;
            end
            ST_LOCK: begin
                if (STOP)
                    nxt = ST_DONE;
                else if (chk_ok) begin
                    if (clean_cnt == CL_W'(LOCK_WORDS - 1)) begin
                        nxt       = ST_RUN;
                        clean_nxt = '0;
                        bad_nxt   = '0;
                    end else
                        clean_nxt = clean_cnt + 1'b1;
                end else if (chk_bad)
                    clean_nxt = '0;
            end
            ST_RUN: begin
                cnt_en = CHK_VALID;
                if (chk_bad) begin
                    if (bad_cnt == BD_W'(LOSS_WORDS - 1)) begin
                        nxt       = ST_LOCK;
                        lost_nxt  = 1'b1;
                        clean_nxt = '0;
                        bad_nxt   = '0;
                    end else
                        bad_nxt = bad_cnt + 1'b1;
                end else if (chk_ok)
                    bad_nxt = '0;
`ifdef PRBS_CTRL_WORD_LIMIT_EN
                if (CHK_VALID && WORD_CNT == WORD_CNT_W'(TEST_WORDS - 1))
                    nxt = ST_DONE;
`endif
                if (STOP)
                    nxt = ST_DONE;
                // An outstanding pulse swallows further requests.
                inj_nxt = INJECT && !GEN_ERR[INJ_BIT] && (nxt == ST_RUN);
            end
            default: nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            flush_cnt <= '0;
            clean_cnt <= '0;
            bad_cnt   <= '0;
            GEN_RST   <= 1'b1;
            CHK_RST   <= 1'b1;
            GEN_EN    <= 1'b0;
            CHK_EN    <= 1'b0;
            GEN_ERR   <= '0;
            BUSY      <= 1'b0;
            LOCKED    <= 1'b0;
            LOCK_LOST <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            state     <= nxt;
            flush_cnt <= flush_nxt;
            clean_cnt <= clean_nxt;
            bad_cnt   <= bad_nxt;
            GEN_RST   <= (nxt == ST_IDLE);
            CHK_RST   <= (nxt == ST_IDLE) || (nxt == ST_FLUSH);
            GEN_EN    <= (nxt == ST_FLUSH) || (nxt == ST_LOCK) || (nxt == ST_RUN);
            CHK_EN    <= (nxt == ST_LOCK) || (nxt == ST_RUN);
            GEN_ERR   <= inj_nxt ? INJ_MASK : '0;
            BUSY      <= (nxt == ST_FLUSH) || (nxt == ST_LOCK) || (nxt == ST_RUN);
            LOCKED    <= (nxt == ST_RUN);
            LOCK_LOST <= lost_nxt;
            DONE      <= (nxt == ST_DONE);
        end
    end

    prbs_sat_counter #(.W(ERR_CNT_W), .INC_W(POP_W)) u_err_cnt (
        .CLK    (CLK),
        .RST    (RST),
        .clr    (clr_cnt),
        .inc_en (cnt_en),
        .inc    (err_pop),
        .cnt    (ERR_CNT)
    );

    prbs_sat_counter #(.W(WORD_CNT_W), .INC_W(1)) u_word_cnt (
        .CLK    (CLK),
        .RST    (RST),
        .clr    (clr_cnt),
        .inc_en (cnt_en),
        .inc    (1'b1),
        .cnt    (WORD_CNT)
    );

endmodule

// File: tb/tb_prbs_test_ctrl.sv
// Scoreboard bench for prbs_test_ctrl; checker responses are driven directly.
module tb_prbs_test_ctrl;

    localparam int NBITS = 16;
    localparam int EW    = 8;
    localparam int WW    = 48;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            START = 1'b0, STOP = 1'b0, INJECT = 1'b0, CHK_VALID = 1'b0;
    logic [NBITS-1:0] CHK_ERR = '0;
    logic            GEN_RST, GEN_EN, CHK_RST, CHK_EN, BUSY, LOCKED, LOCK_LOST, DONE;
    logic [NBITS-1:0] GEN_ERR;
    logic [EW-1:0]   ERR_CNT;
    logic [WW-1:0]   WORD_CNT;

    prbs_test_ctrl #(
        .NBITS(NBITS), .LOCK_WORDS(64), .LOSS_WORDS(4), .FLUSH_CYC(8),
        .ERR_CNT_W(EW), .WORD_CNT_W(WW), .INJ_BIT(0), .TEST_WORDS(100)
    ) dut (
        .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .INJECT(INJECT),
        .CHK_VALID(CHK_VALID), .CHK_ERR(CHK_ERR),
        .GEN_RST(GEN_RST), .GEN_EN(GEN_EN), .GEN_ERR(GEN_ERR),
        .CHK_RST(CHK_RST), .CHK_EN(CHK_EN), .BUSY(BUSY), .LOCKED(LOCKED),
        .LOCK_LOST(LOCK_LOST), .DONE(DONE), .ERR_CNT(ERR_CNT), .WORD_CNT(WORD_CNT)
    );

    always #5 CLK = ~CLK;

    localparam int S_GRST = 0, S_GEN = 1, S_GERR = 2, S_CRST = 3, S_CEN = 4, S_BUSY = 5;
    localparam int S_LCK = 6, S_LOST = 7, S_DONE = 8, S_ERR = 9, S_WORD = 10, S_INJP = 11;

    typedef struct {
        string       name;
        int          sel;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   inj_pulses = 0;

    function automatic logic [63:0] dut_val(input int s);
        case (s)
            S_GRST: return 64'(GEN_RST);
            S_GEN:  return 64'(GEN_EN);
            S_GERR: return 64'(GEN_ERR);
            S_CRST: return 64'(CHK_RST);
            S_CEN:  return 64'(CHK_EN);
            S_BUSY: return 64'(BUSY);
            S_LCK:  return 64'(LOCKED);
            S_LOST: return 64'(LOCK_LOST);
            S_DONE: return 64'(DONE);
            S_ERR:  return 64'(ERR_CNT);
            S_WORD: return 64'(WORD_CNT);
            S_INJP: return 64'(inj_pulses);
            default: return '1;
        endcase
    endfunction

    // Monitor: outputs are registered, so the negedge sees the post-edge state.
    always @(negedge CLK) begin
        exp_t e;
        logic [63:0] act;
        if (GEN_ERR != '0) inj_pulses = inj_pulses + 1;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            act = dut_val(e.sel);
            n_tests = n_tests + 1;
            if (act !== e.val) begin
                n_fail = n_fail + 1;
                $display("FAIL %s: got %0h, expected %0h", e.name, act, e.val);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string n, input int s, input logic [63:0] v);
        exp_t e;
        e.name = n; e.sel = s; e.val = v;
        sb.push_back(e);
    endtask

    task automatic chk_st(input string t, input logic b, input logic l, input logic lo, input logic d);
        chk({t, ".busy"},   S_BUSY, 64'(b));
        chk({t, ".locked"}, S_LCK,  64'(l));
        chk({t, ".lost"},   S_LOST, 64'(lo));
        chk({t, ".done"},   S_DONE, 64'(d));
    endtask

    task automatic chk_cnt(input string t, input int e, input int w);
        chk({t, ".err_cnt"},  S_ERR,  64'(e));
        chk({t, ".word_cnt"}, S_WORD, 64'(w));
    endtask

    task automatic chk_reset(input string t);
        chk_st(t, 0, 0, 0, 0);
        chk_cnt(t, 0, 0);
        chk({t, ".gen_rst"}, S_GRST, 1);
        chk({t, ".chk_rst"}, S_CRST, 1);
        chk({t, ".gen_en"},  S_GEN,  0);
        chk({t, ".chk_en"},  S_CEN,  0);
        chk({t, ".gen_err"}, S_GERR, 0);
    endtask

    task automatic feed(input logic [NBITS-1:0] w, input int n);
        CHK_VALID = 1'b1;
        CHK_ERR   = w;
        repeat (n) tick();
        CHK_VALID = 1'b0;
        CHK_ERR   = '0;
    endtask

    task automatic go_run();
        START = 1'b1;
        tick();
        START = 1'b0;
        repeat (8) tick();
        feed('0, 64);
    endtask

    initial begin
        tick();
        tick();
        chk_reset("reset");
        RST = 1'b0;
        tick();
`ifdef PRBS_CTRL_WORD_LIMIT_EN
        go_run();
        chk("limit.locked", S_LCK, 1);
        feed('0, 99);
        chk_st("limit.99", 1, 1, 0, 0);
        chk_cnt("limit.99", 0, 99);
        feed('0, 1);
        chk_st("limit.100", 0, 0, 0, 1);
        chk_cnt("limit.100", 0, 100);
`else
        // Flush timing and lock acquisition on clean loopback.
        START = 1'b1;
        tick();
        START = 1'b0;
        chk_st("flush.start", 1, 0, 0, 0);
        chk("flush.gen_rst", S_GRST, 0);
        chk("flush.gen_en",  S_GEN,  1);
        chk("flush.chk_rst", S_CRST, 1);
        chk("flush.chk_en",  S_CEN,  0);
        repeat (7) tick();
        chk("flush.last.chk_rst", S_CRST, 1);
        chk("flush.last.chk_en",  S_CEN,  0);
        tick();
        chk("lock.chk_rst", S_CRST, 0);
        chk("lock.chk_en",  S_CEN,  1);
        chk("lock.locked",  S_LCK,  0);
        feed('0, 63);
        chk("lock.63.locked", S_LCK, 0);
        feed('0, 1);
        chk_st("lock.64", 1, 1, 0, 0);
        chk_cnt("lock.64", 0, 0);
        feed('0, 500);
        tick();
        feed('0, 500);
        chk_cnt("run.1000", 0, 1000);
        STOP = 1'b1;
        tick();
        STOP = 1'b0;
        chk_st("stop", 0, 0, 0, 1);
        chk_cnt("stop", 0, 1000);
        chk("stop.gen_en",  S_GEN,  0);
        chk("stop.chk_en",  S_CEN,  0);
        chk("stop.gen_rst", S_GRST, 0);
        chk("stop.chk_rst", S_CRST, 0);
        INJECT = 1'b1;
        tick();
        INJECT = 1'b0;
        chk("done.inject.gen_err", S_GERR, 0);

        // Restart, inject once in LOCK (ignored) and twice back-to-back in RUN.
        START = 1'b1;
        tick();
        START = 1'b0;
        chk_st("restart", 1, 0, 0, 0);
        chk_cnt("restart", 0, 0);
        repeat (8) tick();
        INJECT = 1'b1;
        feed('0, 1);
        INJECT = 1'b0;
        feed('0, 63);
        chk("inj.locked", S_LCK, 1);
        chk("inj.lock.pulses", S_INJP, 0);
        INJECT = 1'b1;
        tick();
        chk("inj.gen_err.on", S_GERR, 64'h0001);
        tick();
        INJECT = 1'b0;
        chk("inj.gen_err.off", S_GERR, 0);
        feed(16'h0011, 1);
        feed(16'h0200, 1);
        feed('0, 2);
        chk("inj.pulses", S_INJP, 1);
        chk_st("inj", 1, 1, 0, 0);
        chk_cnt("inj", 3, 4);

        // Four consecutive fully errored words drop lock, then relock.
        feed(16'hFFFF, 3);
        chk("loss.3.locked", S_LCK, 1);
        chk("loss.3.err_cnt", S_ERR, 51);
        feed(16'hFFFF, 1);
        chk_st("loss.4", 1, 0, 1, 0);
        chk_cnt("loss.4", 67, 8);
        feed('0, 63);
        chk("relock.63.locked", S_LCK, 0);
        feed('0, 1);
        chk_st("relock", 1, 1, 1, 0);
        chk_cnt("relock", 67, 8);

        // Saturation of the 8-bit error counter; clean words reset the loss run.
        repeat (3) begin feed(16'hFFFF, 3); feed('0, 1); end
        chk("sat.3.locked", S_LCK, 1);
        chk_cnt("sat.3", 211, 20);
        feed(16'hFFFF, 3); feed('0, 1);
        chk_cnt("sat.4", 255, 24);
        feed(16'hFFFF, 3); feed('0, 1);
        chk_cnt("sat.5", 255, 28);
        chk("sat.5.locked", S_LCK, 1);

        // STOP coincident with a valid word still counts that word.
        CHK_VALID = 1'b1; CHK_ERR = 16'h0001; STOP = 1'b1;
        tick();
        CHK_VALID = 1'b0; CHK_ERR = '0; STOP = 1'b0;
        chk_st("stop.word", 0, 0, 1, 1);
        chk_cnt("stop.word", 255, 29);

        // START clears counters; START while active is ignored; STOP wins in RUN.
        START = 1'b1;
        tick();
        START = 1'b0;
        chk_st("start.clr", 1, 0, 0, 0);
        chk_cnt("start.clr", 0, 0);
        repeat (8) tick();
        feed('0, 64);
        feed('0, 5);
        chk_cnt("run5", 0, 5);
        START = 1'b1; CHK_VALID = 1'b1;
        tick();
        START = 1'b0; CHK_VALID = 1'b0;
        chk_st("start.active", 1, 1, 0, 0);
        chk_cnt("start.active", 0, 6);
        START = 1'b1; STOP = 1'b1;
        tick();
        START = 1'b0; STOP = 1'b0;
        chk_st("startstop.run", 0, 0, 0, 1);
        chk_cnt("startstop.run", 0, 6);

        // From IDLE, START wins over STOP; then RST mid-RUN.
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk_reset("rst.done");
        START = 1'b1; STOP = 1'b1;
        tick();
        START = 1'b0; STOP = 1'b0;
        chk_st("startstop.idle", 1, 0, 0, 0);
        chk("startstop.idle.gen_en", S_GEN, 1);
        repeat (8) tick();
        feed('0, 64);
        feed(16'h0101, 3);
        chk_st("pre.rst", 1, 1, 0, 0);
        chk_cnt("pre.rst", 6, 3);
        RST = 1'b1; CHK_VALID = 1'b1; CHK_ERR = 16'hFFFF; INJECT = 1'b1;
        tick();
        RST = 1'b0; CHK_VALID = 1'b0; CHK_ERR = '0; INJECT = 1'b0;
        chk_reset("rst.run");
`endif
        tick();
        tick();
        n_tests = n_tests + 1;
        if (BUSY !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL final.busy: got %0b, expected 0", BUSY);
        end
        n_tests = n_tests + 1;
        if (LOCKED !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL final.locked: got %0b, expected 0", LOCKED);
        end
        n_tests = n_tests + 1;
        if (GEN_EN !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL final.gen_en: got %0b, expected 0", GEN_EN);
        end
        n_tests = n_tests + 1;
        if (sb.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL final.scoreboard: got %0d pending, expected 0", sb.size());
        end
        if (n_tests < 12) begin
            n_fail = n_fail + 1;
            $display("FAIL final.count: got %0d tests, expected at least 12", n_tests);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prbs_test_ctrl.md
Name: prbs_test_ctrl

Overview:
- Sequencer for one PRBS generator/checker pair on a transceiver lane during link BER test.
- Drives the generator's enable, reset and error-inject bus, and the checker's enable and reset.
- Consumes the checker's per-bit error word, acquires and tracks lock, and accumulates saturating error and word counts for register readout.

Parameters:
NBITS, 16, width of the generator and checker data buses
LOCK_WORDS, 64, consecutive error-free valid words required to declare lock
LOSS_WORDS, 4, consecutive errored valid words in RUN that drop lock
FLUSH_CYC, 8, cycles the checker is held in reset/flush after START
ERR_CNT_W, 32, error counter width (saturating)
WORD_CNT_W, 48, checked-word counter width (saturating)
INJ_BIT, 0, bit index of GEN_ERR flipped by an inject request
TEST_WORDS, 2**20, RUN duration in valid words (used only with PRBS_CTRL_WORD_LIMIT_EN)

Ports:
CLK  in  1  system clock
RST  in  1  synchronous reset, active-high
START  in  1  pulse: begin or restart a test
STOP  in  1  pulse: end the test, go to DONE
INJECT  in  1  pulse: request a single-bit error injection
CHK_VALID  in  1  CHK_ERR qualifier (checker enable as seen at the checker output)
CHK_ERR  in  NBITS  checker error word, 1 = bit error
GEN_RST  out  1  generator synchronous reset
GEN_EN  out  1  generator enable
GEN_ERR  out  NBITS  generator error-inject bus
CHK_RST  out  1  checker synchronous reset
CHK_EN  out  1  checker enable
BUSY  out  1  state is not IDLE and not DONE
LOCKED  out  1  state is RUN
LOCK_LOST  out  1  sticky: lock dropped at least once since START
DONE  out  1  state is DONE
ERR_CNT  out  ERR_CNT_W  accumulated bit errors
WORD_CNT  out  WORD_CNT_W  valid words checked in RUN

Behaviour:
- Reset values:
  - GEN_RST=1, CHK_RST=1.
  - GEN_EN, CHK_EN, GEN_ERR, BUSY, LOCKED, LOCK_LOST, DONE, ERR_CNT, WORD_CNT all 0.
  - State IDLE.
- All outputs are registered.
- IDLE:
  - GEN_RST=1, CHK_RST=1, enables 0.
  - START -> FLUSH. Clear ERR_CNT, WORD_CNT, LOCK_LOST. Load the flush counter with FLUSH_CYC-1.
- FLUSH:
  - GEN_RST=0, GEN_EN=1, CHK_RST=1, CHK_EN=0.
  - Counter decrements each cycle. At 0 -> LOCK, with CHK_RST=0 and CHK_EN=1 from the next cycle.
- LOCK:
  - Generator and checker enabled.
  - Clean-word counter increments on CHK_VALID && CHK_ERR==0. Clears on CHK_VALID && CHK_ERR!=0.
  - Reaching LOCK_WORDS -> RUN.
  - Errors in LOCK are not counted.
- RUN:
  - Per CHK_VALID word: WORD_CNT += 1 and ERR_CNT += popcount(CHK_ERR), both saturating at all-ones.
  - Bad-word counter counts consecutive errored words. Reaching LOSS_WORDS -> LOCK with LOCK_LOST=1 and the clean counter cleared.
  - Errors from the word that triggers loss are still counted.
- DONE: enables 0, resets deasserted, counters frozen. START -> FLUSH (counters cleared).
- STOP in FLUSH, LOCK or RUN -> DONE next cycle. The word on CHK_ERR in that cycle is still counted if in RUN.
- Simultaneous START and STOP: STOP wins in active states; START wins in IDLE and DONE.
- START while active: ignored.
- INJECT:
  - Honoured only in RUN: GEN_ERR[INJ_BIT]=1 for exactly one cycle, next cycle.
  - Ignored in all other states.
  - A second INJECT while the pulse is outstanding is dropped.
- Expected checker response to one injected bit: 3 error bits, spread over at most the next ceil(POLY_LENGHT/NBITS)+1 words.
- RST mid-operation: immediate return to reset values on the next edge; no partial counts are retained.

Optional Feature:
- Macro: PRBS_CTRL_WORD_LIMIT_EN.
- Defined: RUN ends automatically when WORD_CNT reaches TEST_WORDS -> DONE. STOP still works earlier.
- Undefined: RUN lasts until STOP, and TEST_WORDS is unused.

Decomposition:
- Package prbs_ctrl_pkg holds:
  - the state enum (IDLE, FLUSH, LOCK, RUN, DONE);
  - a popcount function parameterised on NBITS;
  - a saturating-add helper.
- One sub-module, prbs_sat_counter (width parameter, increment input, clear, saturate-at-max), is instantiated for ERR_CNT and WORD_CNT.

Test Plan:
- Loopback generator->checker with no errors, START: FLUSH lasts 8 cycles, LOCKED rises after 64 valid words, ERR_CNT stays 0. STOP after 1000 RUN words -> DONE=1, WORD_CNT=1000.
- INJECT once in RUN: GEN_ERR=16'h0001 for one cycle, ERR_CNT=3, LOCKED stays 1.
- Force CHK_ERR=16'hFFFF for 4 valid words in RUN: ERR_CNT += 64, LOCKED=0, LOCK_LOST=1. After 64 clean words, LOCKED=1 again.
- Preload ERR_CNT near max (ERR_CNT_W=8 build), feed errors: ERR_CNT holds at 8'hFF.
- START and STOP in the same cycle from IDLE -> FLUSH; then in RUN -> DONE. RST asserted in RUN: all outputs at reset values the next cycle.
- PRBS_CTRL_WORD_LIMIT_EN defined, TEST_WORDS=100: DONE asserted after WORD_CNT=100 with no STOP.
